// File: rtl/key_debounce.sv
// key_debounce: debounced active-low push-button input.
//
// Synchronises a raw key pin to CLK_IN, rejects contact bounce shorter than
// DEBOUNCE_CYCLES, and produces a stable pressed level plus one-cycle press,
// release and long-press events. A wrapping 8-bit counter tallies presses.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive changed samples needed to accept a new level (>= 2)
//   LONG_CYCLES     - hold duration, counted from the press event, for key_long
//                     (> DEBOUNCE_CYCLES)
//
// Ports:
//   CLK_IN      - clock
//   RST_N       - asynchronous active-low reset
//   KEY_N       - raw key pin, asynchronous, 0 = pressed
//   key_level   - debounced level, 1 = pressed
//   key_press   - one-cycle pulse on an accepted press
//   key_release - one-cycle pulse on an accepted release
//   key_long    - one-cycle pulse once per press when the hold reaches LONG_CYCLES
//   press_count - accepted presses, modulo 256
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 240_000,
    parameter int unsigned LONG_CYCLES     = 24_000_000
) (
    input  logic       CLK_IN,
    input  logic       RST_N,
    input  logic       KEY_N,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic       key_long,
    output logic [7:0] press_count
);

    localparam int unsigned DebW  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HoldW = $clog2(LONG_CYCLES);

    localparam logic [DebW-1:0]  DebMax  = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLongHeld
    } state_e;

    logic             sync_meta_q;
    logic             sync_q;
    logic [DebW-1:0]  deb_cnt_q;
    logic [HoldW-1:0] hold_cnt_q;
    state_e           state_q;

    logic sample_pressed;
    logic differs;
    logic accept;
    logic accept_press;
    logic accept_release;

    // Two-flop synchroniser; resets to the released pin level.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
        end else begin
            sync_meta_q <= KEY_N;
            sync_q      <= sync_meta_q;
        end
    end

    // The FSM reacts to the acceptance itself rather than to the registered
    // level, so key_press/key_release land on the same edge as the level change.
    always_comb begin
        sample_pressed = ~sync_q;
        differs        = (sample_pressed != key_level);
        accept         = differs && (deb_cnt_q == DebMax);
        accept_press   = accept && !key_level;
        accept_release = accept && key_level;
    end

    // Debounce: any sample matching the current level restarts the count.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            deb_cnt_q <= '0;
            key_level <= 1'b0;
        end else if (!differs) begin
            deb_cnt_q <= '0;
        end else if (accept) begin
            deb_cnt_q <= '0;
            key_level <= ~key_level;
        end else begin
            deb_cnt_q <= deb_cnt_q + DebW'(1);
        end
    end

    // Event FSM with registered pulse outputs.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            press_count <= 8'd0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept_press) begin
                        state_q     <= StPressed;
                        key_press   <= 1'b1;
                        press_count <= press_count + 8'd1;
                        hold_cnt_q  <= '0;
                    end
                end
                StPressed: begin
                    // Release takes priority over a long-press on the same edge.
                    if (accept_release) begin
                        state_q     <= StIdle;
                        key_release <= 1'b1;
                    end else if (hold_cnt_q == HoldMax) begin
                        state_q  <= StLongHeld;
                        key_long <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end
                StLongHeld: begin
                    // Hold counter stays frozen here until the next press.
                    if (accept_release) begin
                        state_q     <= StIdle;
                        key_release <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_debounce;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Long = 20;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic       key_level;
    logic       key_press;
    logic       key_release;
    logic       key_long;
    logic [7:0] press_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Event tallies, sampled on the rising edge (pre-update values).
    int n_press    = 0;
    int n_rel      = 0;
    int n_long     = 0;
    int excl_viol  = 0;

    typedef struct {
        logic       key_n;
        logic       lvl;
        logic       pr;
        logic       rl;
        logic       lg;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[17];

    key_debounce #(
        .DEBOUNCE_CYCLES(Deb),
        .LONG_CYCLES    (Long)
    ) dut (
        .CLK_IN     (clk),
        .RST_N      (rst_n),
        .KEY_N      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (key_press)   n_press <= n_press + 1;
        if (key_release) n_rel   <= n_rel + 1;
        if (key_long)    n_long  <= n_long + 1;
        if ((int'(key_press) + int'(key_release) + int'(key_long)) > 1)
            excl_viol <= excl_viol + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic lvl, input logic pr,
                              input logic rl, input logic lg, input logic [7:0] cnt);
        logic [11:0] exp_v;
        logic [11:0] act_v;
        exp_v = {lvl, pr, rl, lg, cnt};
        act_v = {key_level, key_press, key_release, key_long, press_count};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got level/press/release/long=%b count=%0d, want %b count=%0d",
                     name, act_v[11:8], act_v[7:0], exp_v[11:8], exp_v[7:0]);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
        end
    endtask

    initial begin
        int p0, r0, l0;
        logic [7:0] exp_cnt;

        // Clean press/release: one row per cycle, key sampled on the next rising edge.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

        // 1. Reset defaults.
        tick(3);
        check_outs("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            check_outs("reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // 2. Clean press and release from the vector table.
        for (int i = 0; i < 17; i++) begin
            key_n = vecs[i].key_n;
            tick(1);
            check_outs($sformatf("vec[%0d]", i), vecs[i].lvl, vecs[i].pr, vecs[i].rl,
                       vecs[i].lg, vecs[i].cnt);
        end

        // 3. Bounce rejection: runs of 3 samples never complete a 4-sample count.
        tick(2);
        p0 = n_press; r0 = n_rel; l0 = n_long;
        for (int s = 0; s < 10; s++) begin
            key_n = (s % 2 == 1);
            tick(3);
            check_outs("bounce_level", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        end
        check_int("bounce_quiet", n_press - p0 + n_rel - r0 + n_long - l0, 0);
        key_n = 1'b0;
        tick(5);
        check_outs("bounce_pre", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        tick(1);
        check_outs("bounce_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd2);
        tick(2);
        key_n = 1'b1;
        tick(10);
        check_int("bounce_npress", n_press - p0, 1);
        check_int("bounce_nrel", n_rel - r0, 1);
        check_int("bounce_nlong", n_long - l0, 0);

        // 4. Long press: key_long exactly LONG_CYCLES edges after key_press.
        p0 = n_press; r0 = n_rel; l0 = n_long;
        key_n = 1'b0;
        tick(6);
        check_outs("long_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd3);
        for (int i = 1; i <= 25; i++) begin
            tick(1);
            check_int($sformatf("long_pulse[%0d]", i), int'(key_long), (i == 20) ? 1 : 0);
        end
        tick(29);
        key_n = 1'b1;
        tick(5);
        check_outs("long_pre_rel", 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);
        tick(1);
        check_outs("long_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
        tick(3);
        check_int("long_npress", n_press - p0, 1);
        check_int("long_nrel", n_rel - r0, 1);
        check_int("long_nlong", n_long - l0, 1);

        // 5a. Release accepted on the very edge key_long would otherwise fire.
        p0 = n_press; r0 = n_rel; l0 = n_long;
        key_n = 1'b0;
        tick(6);
        check_outs("coll_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd4);
        tick(14);
        key_n = 1'b1;
        tick(5);
        check_outs("coll_pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'd4);
        tick(1);
        check_outs("coll_release", 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
        tick(25);
        check_int("coll_nrel", n_rel - r0, 1);
        check_int("coll_nlong", n_long - l0, 0);

        // 5b. 256 short presses: press_count wraps through 255 -> 0.
        exp_cnt = 8'd4;
        for (int i = 0; i < 256; i++) begin
            key_n = 1'b0;
            tick(8);
            key_n = 1'b1;
            tick(8);
            exp_cnt = exp_cnt + 8'd1;
            if (exp_cnt == 8'd0 || i == 255)
                check_int($sformatf("wrap[%0d]", i), int'(press_count), int'(exp_cnt));
        end
        check_int("wrap_final", int'(press_count), 4);
        check_int("wrap_nlong", n_long - l0, 0);

        // 6. Reset while pressed, key still held across reset.
        key_n = 1'b0;
        tick(6);
        check_outs("rst_press0", 1'b1, 1'b1, 1'b0, 1'b0, 8'd5);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(2);
        check_outs("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;
        tick(5);
        check_outs("rst_pre", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick(1);
        check_outs("rst_press", 1'b1, 1'b1, 1'b0, 1'b0, 8'd1);
        tick(2);
        check_outs("rst_held", 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        key_n = 1'b1;
        tick(8);
        check_outs("rst_released", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

        check_int("exclusive", excl_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
